// File: rtl/lsu_axi_pkg.sv
// Shared constants, FSM state type and burst context for the LSU-side AXI4 memory responder.
// Pure declarations: no latency, no flow control.
package lsu_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_8B     = 3'd3;

   // Context fields are sized for the widest supported ID and word index.
   localparam int CTX_ID_W  = 16;
   localparam int CTX_IDX_W = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WDATA,
      S_WRESP,
      S_RDATA
   } axi_slv_state_e;

   typedef struct packed {
      logic [CTX_ID_W-1:0]  id;
      logic [CTX_IDX_W-1:0] idx;
      logic [7:0]           len;
      logic [7:0]           cnt;
      logic [1:0]           resp;
   } burst_ctx_t;

   function automatic logic [1:0] resolve_resp(input logic       addr_oob,
                                               input logic [2:0] size,
                                               input logic [1:0] burst);
      if (addr_oob) return RESP_DECERR;
      if (size != SIZE_8B || burst != BURST_INCR) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/lsu_axi_mem_array.sv
// MEM_DEPTH x DATA_W storage: byte-enabled synchronous write, combinational read.
// Write lands at the clock edge; read reflects the addressed word in the same cycle. No backpressure.
module lsu_axi_mem_array #(
   parameter int DATA_W    = 64,
   parameter int MEM_DEPTH = 1024,
   parameter int IDX_W     = $clog2(MEM_DEPTH),
   parameter int STRB_W    = DATA_W / 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [STRB_W-1:0] wr_strb,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_dat
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   // Contents are deliberately not reset so data survives an arst_n pulse.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) mem_q[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
         end
      end
   end

   assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/lsu_axi_slave_mem.sv
// AXI4 slave memory: one write or read burst at a time; B one cycle after last W, R one cycle after AR.
// Master stalls via BREADY/RREADY hold the registered response; AR waits while a write address is offered.
module lsu_axi_slave_mem
   import lsu_axi_pkg::*;
#(
   parameter int ID_W      = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int MEM_DEPTH = 1024,
   parameter int STRB_W    = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ID_W-1:0]   AWID,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic [7:0]        AWLEN,
   input  logic [2:0]        AWSIZE,
   input  logic [1:0]        AWBURST,
   input  logic [3:0]        AWREGION,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [DATA_W-1:0] WDATA,
   input  logic [STRB_W-1:0] WSTRB,
   input  logic              WLAST,
   input  logic              WVALID,
   output logic              WREADY,
   output logic [ID_W-1:0]   BID,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   input  logic [ID_W-1:0]   ARID,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic [7:0]        ARLEN,
   input  logic [2:0]        ARSIZE,
   input  logic [1:0]        ARBURST,
   input  logic [3:0]        ARREGION,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [ID_W-1:0]   RID,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              RLAST,
   output logic              RVALID,
   input  logic              RREADY
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   axi_slv_state_e    state_q, state_d;
   burst_ctx_t        ctx_q, ctx_d;
   logic              wlast_err_q, wlast_err_d;
   logic              awready_q, awready_d, arready_q, arready_d, wready_q, wready_d;
   logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [ID_W-1:0]   bid_q, bid_d, rid_q, rid_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [IDX_W-1:0]  aw_idx, ar_idx, cur_idx, nxt_idx, rd_idx;
   logic [1:0]        aw_resp, ar_resp;
   logic              aw_hs, ar_hs, w_beat_last, w_err;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_rd_dat;
   logic              unused_sink;

   assign aw_idx  = AWADDR[3 +: IDX_W];
   assign ar_idx  = ARADDR[3 +: IDX_W];
   assign cur_idx = ctx_q.idx[IDX_W-1:0];
   assign nxt_idx = cur_idx + IDX_W'(1);
   assign aw_resp = resolve_resp(|AWADDR[ADDR_W-1:IDX_W+3], AWSIZE, AWBURST);
   assign ar_resp = resolve_resp(|ARADDR[ADDR_W-1:IDX_W+3], ARSIZE, ARBURST);
   assign rd_idx  = (state_q == S_IDLE) ? ar_idx : nxt_idx;

   // A concurrent write address takes priority, so AR must not complete a handshake beside it.
   assign ARREADY = arready_q & ~AWVALID;
   assign aw_hs   = AWVALID & awready_q;
   assign ar_hs   = ARVALID & ARREADY;

   always_comb begin
      state_d     = state_q;
      ctx_d       = ctx_q;
      wlast_err_d = wlast_err_q;
      awready_d   = awready_q;
      arready_d   = arready_q;
      wready_d    = wready_q;
      bvalid_d    = bvalid_q;
      bid_d       = bid_q;
      bresp_d     = bresp_q;
      rvalid_d    = rvalid_q;
      rid_d       = rid_q;
      rresp_d     = rresp_q;
      rlast_d     = rlast_q;
      rdata_d     = rdata_q;
      mem_wr_en   = 1'b0;
      w_beat_last = (ctx_q.cnt == ctx_q.len);
      w_err       = wlast_err_q | (WLAST != w_beat_last);
      case (state_q)
         S_IDLE: begin
            awready_d = 1'b1;
            arready_d = 1'b1;
            if (aw_hs) begin
               state_d     = S_WDATA;
               ctx_d.id    = CTX_ID_W'(AWID);
               ctx_d.idx   = CTX_IDX_W'(aw_idx);
               ctx_d.len   = AWLEN;
               ctx_d.cnt   = 8'd0;
               ctx_d.resp  = aw_resp;
               wlast_err_d = 1'b0;
               awready_d   = 1'b0;
               arready_d   = 1'b0;
               wready_d    = 1'b1;
            end else if (ar_hs) begin
               state_d    = S_RDATA;
               ctx_d.id   = CTX_ID_W'(ARID);
               ctx_d.idx  = CTX_IDX_W'(ar_idx);
               ctx_d.len  = ARLEN;
               ctx_d.cnt  = 8'd0;
               ctx_d.resp = ar_resp;
               awready_d  = 1'b0;
               arready_d  = 1'b0;
               rvalid_d   = 1'b1;
               rid_d      = ARID;
               rresp_d    = ar_resp;
               rlast_d    = (ARLEN == 8'd0);
               rdata_d    = (ar_resp == RESP_OKAY) ? mem_rd_dat : '0;
            end
         end
         S_WDATA: begin
            if (WVALID && wready_q) begin
               mem_wr_en = (ctx_q.resp == RESP_OKAY);
               if (w_beat_last) begin
                  state_d  = S_WRESP;
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bid_d    = ID_W'(ctx_q.id);
                  bresp_d  = (ctx_q.resp != RESP_OKAY) ? ctx_q.resp :
                             (w_err ? RESP_SLVERR : RESP_OKAY);
               end else begin
                  ctx_d.cnt   = ctx_q.cnt + 8'd1;
                  ctx_d.idx   = CTX_IDX_W'(nxt_idx);
                  wlast_err_d = w_err;
               end
            end
         end
         S_WRESP: begin
            if (BREADY) begin
               state_d   = S_IDLE;
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               arready_d = 1'b1;
            end
         end
         S_RDATA: begin
            if (RREADY) begin
               if (rlast_q) begin
                  state_d   = S_IDLE;
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  awready_d = 1'b1;
                  arready_d = 1'b1;
               end else begin
                  ctx_d.cnt = ctx_q.cnt + 8'd1;
                  ctx_d.idx = CTX_IDX_W'(nxt_idx);
                  rlast_d   = (ctx_q.cnt + 8'd1 == ctx_q.len);
                  rdata_d   = (ctx_q.resp == RESP_OKAY) ? mem_rd_dat : '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ctx_q       <= '0;
         wlast_err_q <= 1'b0;
         awready_q   <= 1'b0;
         arready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bid_q       <= '0;
         bresp_q     <= '0;
         rvalid_q    <= 1'b0;
         rid_q       <= '0;
         rresp_q     <= '0;
         rlast_q     <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         ctx_q       <= ctx_d;
         wlast_err_q <= wlast_err_d;
         awready_q   <= awready_d;
         arready_q   <= arready_d;
         wready_q    <= wready_d;
         bvalid_q    <= bvalid_d;
         bid_q       <= bid_d;
         bresp_q     <= bresp_d;
         rvalid_q    <= rvalid_d;
         rid_q       <= rid_d;
         rresp_q     <= rresp_d;
         rlast_q     <= rlast_d;
         rdata_q     <= rdata_d;
      end
   end

   lsu_axi_mem_array #(
      .DATA_W   (DATA_W),
      .MEM_DEPTH(MEM_DEPTH),
      .IDX_W    (IDX_W),
      .STRB_W   (STRB_W)
   ) u_mem (
      .clk    (clk),
      .wr_en  (mem_wr_en),
      .wr_idx (cur_idx),
      .wr_strb(WSTRB),
      .wr_dat (WDATA),
      .rd_idx (rd_idx),
      .rd_dat (mem_rd_dat)
   );

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BID     = bid_q;
   assign BRESP   = bresp_q;
   assign RVALID  = rvalid_q;
   assign RID     = rid_q;
   assign RRESP   = rresp_q;
   assign RLAST   = rlast_q;
   assign RDATA   = rdata_q;

   // Region, sub-word address bits and context padding carry no meaning here.
   assign unused_sink = ^{AWADDR[2:0], ARADDR[2:0], AWREGION, ARREGION, ctx_q};

endmodule

// File: tb/tb_lsu_axi_slave_mem.sv
// Randomised and directed bench for lsu_axi_slave_mem against an array-based memory model.
module tb_lsu_axi_slave_mem;

   localparam int TMO = 2000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  AWID, ARID, BID, RID, AWREGION, ARREGION;
   logic [31:0] AWADDR, ARADDR;
   logic [7:0]  AWLEN, ARLEN, WSTRB;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [63:0] WDATA, RDATA;

   lsu_axi_slave_mem dut (
      .clk(clk), .rst_n(rst_n),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] model_mem [1024];
   logic [63:0] wbuf [256];
   logic [7:0]  sbuf [256];
   logic [63:0] rd_dat [256];
   logic [1:0]  rd_resp [256];
   logic        rd_last [256];
   logic [3:0]  rd_id [256];
   time         b_time, ar_time;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst);
      if ((addr >> 13) != 0) return 2'b11;
      if (size != 3'd3 || burst != 2'b01) return 2'b10;
      return 2'b00;
   endfunction

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bstall);
      int n;
      logic [3:0] bid_s;
      logic [1:0] bresp_s, er;
      int base;
      @(negedge clk);
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
      AWREGION = 4'($urandom); AWVALID = 1'b1;
      #1; n = 0;
      while (!AWREADY && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("aw_timeout", 64'(AWREADY), 64'd1);
      @(negedge clk);
      AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         WDATA = wbuf[b]; WSTRB = sbuf[b]; WLAST = (b == int'(len)); WVALID = 1'b1;
         #1; n = 0;
         while (!WREADY && n < TMO) begin @(negedge clk); #1; n++; end
         if (n >= TMO) chk("w_timeout", 64'(WREADY), 64'd1);
         @(negedge clk);
      end
      WVALID = 1'b0; WLAST = 1'b0;
      chk("b_latency", 64'(BVALID), 64'd1);
      for (int k = 0; k < bstall; k++) begin
         @(negedge clk);
         chk("b_hold", 64'(BVALID), 64'd1);
      end
      BREADY = 1'b1;
      #1; n = 0;
      while (!BVALID && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("b_timeout", 64'(BVALID), 64'd1);
      bid_s = BID; bresp_s = BRESP; b_time = $time;
      @(negedge clk);
      BREADY = 1'b0;
      er = exp_resp(addr, size, burst);
      chk("bid", 64'(bid_s), 64'(id));
      chk("bresp", 64'(bresp_s), 64'(er));
      if (er == 2'b00) begin
         base = int'(addr[12:3]);
         for (int b = 0; b <= int'(len); b++)
            for (int y = 0; y < 8; y++)
               if (sbuf[b][y]) model_mem[(base + b) % 1024][y*8 +: 8] = wbuf[b][y*8 +: 8];
      end
   endtask

   // mode 0: RREADY high; 1: toggling 1/0; 2: random
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode);
      int n, cnt, base;
      logic stalled;
      logic [63:0] h_dat;
      logic h_last;
      logic [1:0] er;
      @(negedge clk);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARREGION = 4'($urandom); ARVALID = 1'b1;
      #1; n = 0;
      while (!ARREADY && n < TMO) begin @(negedge clk); #1; n++; end
      if (n >= TMO) chk("ar_timeout", 64'(ARREADY), 64'd1);
      ar_time = $time;
      @(negedge clk);
      ARVALID = 1'b0;
      chk("r_first", 64'(RVALID), 64'd1);
      cnt = 0; n = 0; stalled = 1'b0; h_dat = '0; h_last = 1'b0;
      while (cnt <= int'(len) && n < TMO) begin
         RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom);
         #1;
         if (RVALID) begin
            if (stalled) begin
               chk("r_stable_dat", RDATA, h_dat);
               chk("r_stable_last", 64'(RLAST), 64'(h_last));
            end
            if (RREADY) begin
               rd_dat[cnt] = RDATA; rd_resp[cnt] = RRESP; rd_last[cnt] = RLAST; rd_id[cnt] = RID;
               cnt++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1; h_dat = RDATA; h_last = RLAST;
            end
         end
         @(negedge clk);
         n++;
      end
      RREADY = 1'b0;
      if (cnt <= int'(len)) chk("r_timeout", 64'(cnt), 64'(int'(len) + 1));
      chk("r_done", 64'(RVALID), 64'd0);
      er = exp_resp(addr, size, burst);
      base = int'(addr[12:3]);
      for (int b = 0; b < cnt; b++) begin
         chk("rdata", rd_dat[b], (er == 2'b00) ? model_mem[(base + b) % 1024] : 64'd0);
         chk("rresp", 64'(rd_resp[b]), 64'(er));
         chk("rlast", 64'(rd_last[b]), 64'(b == int'(len)));
         chk("rid", 64'(rd_id[b]), 64'(id));
      end
   endtask

   initial begin
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [7:0]  len;
      rst_n = 1'b0;
      {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWREGION, AWVALID} = '0;
      {WDATA, WSTRB, WLAST, WVALID, BREADY} = '0;
      {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY} = '0;
      #1;
      chk("reset_outs", 64'({AWREADY, ARREADY, WREADY, BVALID, BID, BRESP, RVALID, RID, RRESP, RLAST}), 64'd0);
      chk("reset_rdata", RDATA, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_awready", 64'(AWREADY), 64'd1);
      chk("idle_arready", 64'(ARREADY), 64'd1);

      // Fill the whole array so every later read has a known expectation.
      for (int blk = 0; blk < 4; blk++) begin
         for (int b = 0; b < 256; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'hFF; end
         do_write(4'd0, 32'(blk * 32'h800), 8'd255, 3'd3, 2'b01, 0);
      end

      // Basic four-beat write and read-back
      for (int b = 0; b < 4; b++) begin wbuf[b] = 64'((b + 1) * 'h11); sbuf[b] = 8'hFF; end
      do_write(4'd3, 32'h40, 8'd3, 3'd3, 2'b01, 0);
      do_read(4'd3, 32'h40, 8'd3, 3'd3, 2'b01, 0);
      for (int b = 0; b < 4; b++) chk("t2_data", rd_dat[b], 64'((b + 1) * 'h11));

      // Byte strobes
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
      do_write(4'd1, 32'h0, 8'd0, 3'd3, 2'b01, 0);
      wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
      do_write(4'd1, 32'h0, 8'd0, 3'd3, 2'b01, 0);
      do_read(4'd1, 32'h0, 8'd0, 3'd3, 2'b01, 0);
      chk("t3_strobe", rd_dat[0], 64'hFFFF_FFFF_0000_0000);

      // Simultaneous AW and AR: the write must finish before the read is taken
      wbuf[0] = 64'hA5A5_0000_1234_5678; wbuf[1] = 64'h5A5A_FFFF_8765_4321;
      sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
      fork
         do_write(4'd5, 32'h80, 8'd1, 3'd3, 2'b01, 0);
         do_read(4'd6, 32'h80, 8'd1, 3'd3, 2'b01, 0);
      join
      chk("t4_order", 64'(ar_time > b_time), 64'd1);
      chk("t4_newdata", rd_dat[0], 64'hA5A5_0000_1234_5678);

      // Error responses
      do_read(4'd7, 32'h0001_0000, 8'd0, 3'd3, 2'b01, 0);
      chk("t5_decerr", 64'(rd_resp[0]), 64'd3);
      chk("t5_decerr_data", rd_dat[0], 64'd0);
      wbuf[0] = 64'hDEAD; wbuf[1] = 64'hBEEF; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
      do_write(4'd2, 32'h40, 8'd1, 3'd3, 2'b10, 0);
      do_read(4'd2, 32'h40, 8'd1, 3'd3, 2'b01, 0);
      chk("t5_unchanged", rd_dat[0], 64'h11);

      // Backpressure on R and B
      do_read(4'd9, 32'h100, 8'd7, 3'd3, 2'b01, 1);
      wbuf[0] = 64'h77; sbuf[0] = 8'hFF;
      do_write(4'd9, 32'h200, 8'd0, 3'd3, 2'b01, 5);

      // Index wrap at the top of the array
      for (int b = 0; b < 4; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'hFF; end
      do_write(4'd4, 32'(1022 * 8), 8'd3, 3'd3, 2'b01, 0);
      do_read(4'd4, 32'(1022 * 8), 8'd3, 3'd3, 2'b01, 0);

      // Random mix
      for (int t = 0; t < 40; t++) begin
         addr  = 32'($urandom_range(0, 1023)) << 3;
         size  = 3'd3;
         burst = 2'b01;
         len   = 8'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0: addr = addr | (32'd1 << $urandom_range(13, 31));
            1: size = 3'($urandom_range(0, 2));
            2: burst = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
            default: ;
         endcase
         if ($urandom_range(0, 1) == 0) begin
            for (int b = 0; b <= int'(len); b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'($urandom); end
            do_write(4'($urandom), addr, len, size, burst, $urandom_range(0, 3));
         end else begin
            do_read(4'($urandom), addr, len, size, burst, 2);
         end
      end

      // Reset in the middle of a stalled read burst
      @(negedge clk);
      ARID = 4'd8; ARADDR = 32'h0; ARLEN = 8'd7; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", 64'({AWREADY, ARREADY, WREADY, BVALID, BID, BRESP, RVALID, RID, RRESP, RLAST}), 64'd0);
      chk("midrst_rdata", RDATA, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_awready", 64'(AWREADY), 64'd1);
      chk("post_rst_arready", 64'(ARREADY), 64'd1);
      do_read(4'd8, 32'h40, 8'd3, 3'd3, 2'b01, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
